ps2_key_event_filter: RTL and testbench
=======================================

Name: ps2_key_event_filter

Overview:
Sits between the PS/2 byte decoder and the top-level mode/menu controller. Turns the raw scan-code byte stream into clean, single-cycle-consumable key events, one per physical press or release.
- Resolves the E0 (extended), F0 (break) and E1 (pause) prefixes.
- Suppresses typematic auto-repeat.
- Buffers events in a small FIFO with a valid/ready handshake.
The controller therefore never sees break codes, repeats or prefix bytes.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of 2, at least 2)
TIMEOUT_CYC, 2_000_000, sys_clk cycles a partial prefix sequence may wait for its next byte before being abandoned (20 ms at 100 MHz)
REPEAT_PASS, 0, 1 = forward typematic repeats flagged evt_repeat=1; 0 = drop them

Ports:
sys_clk  in  1  clock
rst_n  in  1  synchronous active-low reset
byte_in  in  8  scan-code byte from PS/2 decoder
byte_valid  in  1  one-cycle strobe, byte_in valid
byte_ovf  in  1  decoder overflow (bytes lost)
flush  in  1  one-cycle: clear held-key table, FIFO and parser
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head when high with evt_valid
evt_code  out  8  base scan code of event
evt_ext  out  1  code was E0-prefixed
evt_release  out  1  1 = release, 0 = press
evt_repeat  out  1  typematic repeat (only if REPEAT_PASS=1)
drop_cnt  out  8  saturating count of events lost to FIFO full or overflow

Behaviour:
- Reset is rst_n low at a sys_clk edge. Reset values:
  - evt_valid=0; evt_code, evt_ext, evt_release, evt_repeat = 0; drop_cnt=0.
  - FIFO empty, parser in IDLE, held table all zero, timeout counter 0.
- Reset or flush mid-sequence discards any partial sequence. Flush does not clear drop_cnt.
- Parser FSM (advances only on byte_valid):
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip=7.
    - 00, AA, EE, FA, FC, FE, FF -> ignored, stay IDLE.
    - Any other byte -> make(ext=0, code), stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 -> drop (fake shift), go IDLE.
    - Other -> make(ext=1), go IDLE.
  - BRK: any byte -> break(ext=0), go IDLE.
  - EXT_BRK:
    - 12 -> drop, go IDLE.
    - Other -> break(ext=1), go IDLE.
  - PAUSE: decrement skip on each byte. At 0 go IDLE; no event is produced.
- Timeout:
  - Counter clears on every byte_valid.
  - In any state other than IDLE, reaching TIMEOUT_CYC forces IDLE with no event.
  - In IDLE the counter is held at 0.
- byte_ovf high in any cycle: parser goes to IDLE, drop_cnt increments. A byte arriving in that same cycle is discarded.
- Held-key table: 512 bits indexed {ext, code}.
  - make, bit clear -> push press, set bit.
  - make, bit set -> typematic repeat. If REPEAT_PASS=1 push press with evt_repeat=1; otherwise drop silently (no drop_cnt).
  - break, bit set -> push release, clear bit.
  - break, bit clear -> drop silently.
  - The table bit is updated even if the FIFO rejects the push.
- FIFO:
  - First-word-fall-through; head drives the evt_* outputs.
  - A pop occurs when evt_valid && evt_ready.
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A rejected push increments drop_cnt; drop_cnt saturates at 255.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Latency: the final byte of a sequence with byte_valid at edge N gives evt_valid=1 after edge N+1 if the FIFO was empty. Events stay in byte order.
- Simultaneous events:
  - flush has priority over byte_valid and pop.
  - rst_n has priority over everything.
- Head outputs hold stable while evt_valid && !evt_ready.

Decomposition:
- Shared package ps2_pkg:
  - Scan-code constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, etc.
  - Existing key codes: enter, esc, arrows, etc.
  - Parser state encoding.
  - 11-bit event word layout {repeat, release, ext, code}.
- One sub-module: ps2_event_fifo, a generic width/depth FWFT FIFO with push_ok/pop and full/empty flags.

Test Plan:
1. Bytes 5A, F0 5A -> press {code=5A, ext=0, rel=0}, then release {5A, rel=1}; exactly 2 events, press visible one cycle after the 5A strobe.
2. E0 75, E0 75, E0 75, E0 F0 75 with REPEAT_PASS=0 -> only press {75, ext=1} and release {75, ext=1}. With REPEAT_PASS=1 -> press, 2 presses with repeat=1, release.
3. E1 14 77 E1 F0 14 F0 77 then 76 -> no pause event; single press {76}. Also AA and FA in IDLE -> no event.
4. Byte E0, then TIMEOUT_CYC idle cycles, then 5A -> press {5A, ext=0}, not extended.
5. evt_ready=0, six distinct makes 1C 1B 23 2B 34 33 -> FIFO holds the first 4, drop_cnt=2; then raise evt_ready -> events pop in order 1C 1B 23 2B.
6. Press 29 (held), pulse flush, then F0 29 -> no release emitted. Then 29 -> press emitted. byte_ovf pulse during F0 -> parser IDLE, drop_cnt+1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, key codes, parser state
// encoding and the 11-bit key-event word used between filter and controller.
package ps2_pkg;

    localparam logic [7:0] PS2_ERR0       = 8'h00;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_BATFAIL    = 8'hFC;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_ERR1       = 8'hFF;

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int EVT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    typedef struct packed {
        logic       rpt;
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    // Controller/keyboard status bytes that never start a key sequence.
    function automatic logic ps2_is_status(input logic [7:0] b);
        logic r;
        case (b)
            PS2_ERR0, PS2_BAT, PS2_ECHO, PS2_ACK,
            PS2_BATFAIL, PS2_RESEND, PS2_ERR1: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through FIFO; a push is also accepted when full
// provided the head is popped in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             push_ok_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             pop_s, push_acc_s;

    assign pop_s      = pop_i && (cnt_q != '0);
    assign push_ok_o  = (cnt_q < (AW + 1)'(DEPTH)) || pop_s;
    assign push_acc_s = push_i && push_ok_o;
    assign full_o     = (cnt_q == (AW + 1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign data_o     = mem_q[rd_q];

    // Occupancy next-state.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_acc_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and count.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_acc_s) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_s) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_event_filter.sv
// Turns raw PS/2 scan-code bytes into press/release events: prefix parsing,
// typematic suppression via a held-key table, and an FWFT event FIFO.
module ps2_key_event_filter
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int REPEAT_PASS = 0
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_ovf,
    input  logic       flush,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       evt_repeat,
    output logic [7:0] drop_cnt
);
    localparam int   TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic RP = (REPEAT_PASS != 0);

    ps2_state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [511:0] held_q;
    logic [7:0] drop_q;
    logic make_s, brk_s, ext_s, held_hit_s, push_s, push_ok_s;
    logic fifo_empty_s, fifo_unused_full_s;
    ps2_evt_t push_word_s, head_s;
    logic [EVT_W-1:0] fifo_dout_s;

    // Parser state register.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || flush) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    // Parser next state, including the stale-prefix timeout.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        if (byte_ovf) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
            tmo_d   = '0;
        end else if (byte_valid) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_in == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (byte_in == PS2_PAUSE) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT:   state_d = (byte_in == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_PAUSE: begin
                    skip_d  = skip_q - 3'd1;
                    state_d = (skip_q == 3'd1) ? ST_IDLE : ST_PAUSE;
                end
                default:  state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q >= TW'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                skip_d  = 3'd0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Parser outputs: the byte completing a make or break sequence.
    always_comb begin
        make_s = 1'b0;
        brk_s  = 1'b0;
        ext_s  = 1'b0;
        if (byte_valid && !byte_ovf) begin
            case (state_q)
                ST_IDLE:    make_s = !(byte_in == PS2_EXT || byte_in == PS2_BRK ||
                                       byte_in == PS2_PAUSE || ps2_is_status(byte_in));
                ST_EXT: begin
                    ext_s  = 1'b1;
                    make_s = (byte_in != PS2_BRK) && (byte_in != PS2_FAKE_SHIFT);
                end
                ST_BRK:     brk_s = 1'b1;
                ST_EXT_BRK: begin
                    ext_s = 1'b1;
                    brk_s = (byte_in != PS2_FAKE_SHIFT);
                end
                default: begin
                    make_s = 1'b0;
                    brk_s  = 1'b0;
                end
            endcase
        end else begin
            make_s = 1'b0;
        end
    end

    assign held_hit_s = held_q[{ext_s, byte_in}];
    assign push_s     = !flush && ((make_s && (!held_hit_s || RP)) || (brk_s && held_hit_s));
    assign push_word_s = '{rpt: make_s && held_hit_s, rel: brk_s, ext: ext_s, code: byte_in};

    // Held-key table; updated even when the FIFO rejects the event.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || flush) begin
            held_q <= '0;
        end else if (make_s && !held_hit_s) begin
            held_q[{ext_s, byte_in}] <= 1'b1;
        end else if (brk_s && held_hit_s) begin
            held_q[{ext_s, byte_in}] <= 1'b0;
        end else begin
            held_q <= held_q;
        end
    end

    // Saturating lost-event counter; survives flush.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if ((byte_ovf || (push_s && !push_ok_s)) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end else begin
            drop_q <= drop_q;
        end
    end

    ps2_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .clr_i     (flush),
        .push_i    (push_s),
        .data_i    (push_word_s),
        .pop_i     (evt_ready && !flush),
        .push_ok_o (push_ok_s),
        .data_o    (fifo_dout_s),
        .full_o    (fifo_unused_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign head_s      = ps2_evt_t'(fifo_dout_s);
    assign evt_valid   = !fifo_empty_s;
    assign evt_code    = head_s.code;
    assign evt_ext     = head_s.ext;
    assign evt_release = head_s.rel;
    assign evt_repeat  = head_s.rpt;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ps2_key_event_filter.sv
// Scoreboard bench for ps2_key_event_filter: one DUT drops repeats, a second
// instance forwards them; expected events are queued as bytes are driven.
module tb_ps2_key_event_filter;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0, byte_ovf = 1'b0, flush = 1'b0;
    logic       evt_ready = 1'b1, rp_sel = 1'b0;
    logic       rp_valid;
    logic       evt_valid, evt_ext, evt_release, evt_repeat;
    logic [7:0] evt_code, drop_cnt;
    logic       rp_evt_valid, rp_evt_ext, rp_evt_release, rp_evt_repeat;
    logic [7:0] rp_evt_code, rp_drop_cnt;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    assign rp_valid = byte_valid && rp_sel;

    always #5 sys_clk = ~sys_clk;

    ps2_key_event_filter #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .REPEAT_PASS(0)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ovf(byte_ovf), .flush(flush), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_release(evt_release),
        .evt_repeat(evt_repeat), .drop_cnt(drop_cnt));

    ps2_key_event_filter #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .REPEAT_PASS(1)) dut_rp (
        .sys_clk(sys_clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(rp_valid),
        .byte_ovf(1'b0), .flush(1'b0), .evt_valid(rp_evt_valid), .evt_ready(1'b1),
        .evt_code(rp_evt_code), .evt_ext(rp_evt_ext), .evt_release(rp_evt_release),
        .evt_repeat(rp_evt_repeat), .drop_cnt(rp_drop_cnt));

    function automatic logic [10:0] ev(input logic rpt, input logic rel, input logic ext,
                                       input logic [7:0] code);
        return {rpt, rel, ext, code};
    endfunction

    // Scoreboard: every accepted head is compared with the oldest expectation.
    always @(negedge sys_clk) begin
        logic [10:0] got, exp;
        if (rst_n && evt_valid && evt_ready && !flush) begin
            got = {evt_repeat, evt_release, evt_ext, evt_code};
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got %h, expected no event", got);
            end else begin
                exp = q0.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL evt_word: got %h, expected %h", got, exp);
                end
            end
        end
        if (rst_n && rp_evt_valid) begin
            got = {rp_evt_repeat, rp_evt_release, rp_evt_ext, rp_evt_code};
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rp_evt_unexpected: got %h, expected no event", got);
            end else begin
                exp = q1.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rp_evt_word: got %h, expected %h", got, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic wait_drain(input string name);
        idle(4);
        for (int i = 0; i < 50; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            idle(1);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending %0d/%0d evt_valid %b, expected 0/0 and 0",
                     name, q0.size(), q1.size(), evt_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        @(negedge sys_clk);
        n_checks++;
        if ({evt_valid, evt_code, evt_ext, evt_release, evt_repeat, drop_cnt} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%h x=%b r=%b p=%b d=%0d, expected all 0",
                     evt_valid, evt_code, evt_ext, evt_release, evt_repeat, drop_cnt);
        end
        do_reset();
    endtask

    task automatic test_make_break();
        do_reset();
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h5A));
        send(8'h5A);
        @(negedge sys_clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_code !== 8'h5A) begin
            n_fail++;
            $display("FAIL press_latency: got v=%b code=%h, expected v=1 code=5a",
                     evt_valid, evt_code);
        end
        @(posedge sys_clk);
        #1;
        q0.push_back(ev(1'b0, 1'b1, 1'b0, 8'h5A));
        send_seq('{8'hF0, 8'h5A});
        wait_drain("make_break");
    endtask

    task automatic test_typematic();
        do_reset();
        rp_sel = 1'b1;
        q0.push_back(ev(1'b0, 1'b0, 1'b1, 8'h75));
        q0.push_back(ev(1'b0, 1'b1, 1'b1, 8'h75));
        q1.push_back(ev(1'b0, 1'b0, 1'b1, 8'h75));
        q1.push_back(ev(1'b1, 1'b0, 1'b1, 8'h75));
        q1.push_back(ev(1'b1, 1'b0, 1'b1, 8'h75));
        q1.push_back(ev(1'b0, 1'b1, 1'b1, 8'h75));
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        rp_sel = 1'b0;
        wait_drain("typematic");
    endtask

    task automatic test_pause_status();
        do_reset();
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h76));
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h76});
        send_seq('{8'hAA, 8'hFA});
        wait_drain("pause_status");
    endtask

    task automatic test_timeout();
        do_reset();
        q0.push_back(ev(1'b0, 1'b0, 1'b1, 8'h75));
        send(8'hE0);
        idle(TMO / 2);
        send(8'h75);
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h5A));
        send(8'hE0);
        idle(TMO + 1);
        send(8'h5A);
        wait_drain("timeout");
    endtask

    task automatic test_fifo_full();
        do_reset();
        evt_ready = 1'b0;
        send_seq('{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33});
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h1C));
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h1B));
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h23));
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h2B));
        idle(3);
        @(negedge sys_clk);
        n_checks++;
        if (drop_cnt !== 8'd2 || evt_valid !== 1'b1 || evt_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL fifo_full_hold: got drop=%0d v=%b code=%h, expected 2 1 1c",
                     drop_cnt, evt_valid, evt_code);
        end
        @(posedge sys_clk);
        #1;
        evt_ready = 1'b1;
        wait_drain("fifo_full");
    endtask

    task automatic test_flush_ovf();
        do_reset();
        byte_ovf = 1'b1;
        idle(1);
        byte_ovf = 1'b0;
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h29));
        send(8'h29);
        wait_drain("flush_press");
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL flush_keeps_drop: got %0d, expected 1", drop_cnt);
        end
        send_seq('{8'hF0, 8'h29});
        q0.push_back(ev(1'b0, 1'b0, 1'b0, 8'h29));
        send(8'h29);
        wait_drain("flush_release");
        byte_ovf = 1'b1;
        send(8'hF0);
        byte_ovf = 1'b0;
        send(8'h29);
        q0.push_back(ev(1'b0, 1'b1, 1'b0, 8'h29));
        send_seq('{8'hF0, 8'h29});
        wait_drain("ovf");
        n_checks++;
        if (drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ovf_drop_cnt: got %0d, expected 2", drop_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1);
        test_reset();
        test_make_break();
        test_typematic();
        test_pause_status();
        test_timeout();
        test_fifo_full();
        test_flush_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
